// File: rtl/reg_writeback_queue_if.sv
// Writeback request channel and register-file write port shared by the
// datapath (master) and the writeback queue (slave).
interface reg_writeback_queue_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData_reg;

    modport master (
        output wb_valid, wb_reg, wb_data,
        input  wb_ready, RegWrite, WriteRegister, WriteData_reg
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data,
        output wb_ready, RegWrite, WriteRegister, WriteData_reg
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// Holds register-file writes while reads are in progress, drains one per free
// cycle in acceptance order and forwards the newest pending value to readers.
module reg_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_writeback_queue_if.slave  wb,
    input  logic                  rd_stall,
    input  logic [AW-1:0]         fwd_reg1,
    input  logic [AW-1:0]         fwd_reg2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DW-1:0]         fwd_data1,
    output logic [DW-1:0]         fwd_data2,
    output logic [CW-1:0]         count,
    output logic                  empty
);

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          reg_write_q, reg_write_d;
    logic [AW-1:0] wr_reg_q, wr_reg_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    logic push, pop;

    // Register-zero requests complete the handshake but are never stored.
    assign wb.wb_ready = (count_q != CW'(DEPTH));
    assign push        = wb.wb_valid && wb.wb_ready && (wb.wb_reg != '0);
    assign pop         = (count_q != '0) && !rd_stall;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        reg_write_d = 1'b0;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{dst: wb.wb_reg, data: wb.wb_data};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            reg_write_d = 1'b1;
            wr_reg_d    = mem_q[rd_ptr_q].dst;
            wr_data_d   = mem_q[rd_ptr_q].data;
            rd_ptr_d    = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            reg_write_q <= reg_write_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wb.RegWrite      = reg_write_q;
    assign wb.WriteRegister = wr_reg_q;
    assign wb.WriteData_reg = wr_data_q;
    assign count            = count_q;
    assign empty            = (count_q == '0) && !reg_write_q;

    logic [AW-1:0] lookup [2];
    logic          hit_c  [2];
    logic [DW-1:0] data_c [2];
    logic [PW-1:0] slot;

    assign lookup[0] = fwd_reg1;
    assign lookup[1] = fwd_reg2;

    // Scan oldest to newest so the newest queued match wins; output stage is lowest.
    always_comb begin
        slot = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            hit_c[p]  = 1'b0;
            data_c[p] = '0;
            if (reg_write_q && (wr_reg_q == lookup[p])) begin
                hit_c[p]  = 1'b1;
                data_c[p] = wr_data_q;
            end
            for (int unsigned j = 0; j < DEPTH; j++) begin
                slot = rd_ptr_q + PW'(j);
                if ((CW'(j) < count_q) && (mem_q[slot].dst == lookup[p])) begin
                    hit_c[p]  = 1'b1;
                    data_c[p] = mem_q[slot].data;
                end
            end
            if (lookup[p] == '0) begin
                hit_c[p]  = 1'b0;
                data_c[p] = '0;
            end
        end
    end

    assign fwd_hit1  = hit_c[0];
    assign fwd_hit2  = hit_c[1];
    assign fwd_data1 = data_c[0];
    assign fwd_data2 = data_c[1];

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Buffers register-file write requests from the datapath writeback stage and drives the write port of the 32x32 register file (RegWrite / WriteRegister / WriteData_reg). The register file cannot read and write in the same cycle, so this block holds pending writes while reads are in progress. It drains one write per free cycle and forwards pending data to the read side so consumers never see stale values.

## Interface
- DEPTH, 4, queue entries; power of two, >= 2
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  writeback request valid
- wb_ready  out  1  queue can accept a request this cycle
- wb_reg  in  AW  destination register
- wb_data  in  DW  write data
- rd_stall  in  1  register file reads in progress this cycle; the write port must stay idle
- RegWrite  out  1  register file write strobe, one-cycle pulse per write
- WriteRegister  out  AW  register file write address
- WriteData_reg  out  DW  register file write data
- fwd_reg1, fwd_reg2  in  AW  read-side lookup addresses
- fwd_hit1, fwd_hit2  out  1  pending write exists for the lookup address
- fwd_data1, fwd_data2  out  DW  newest pending data for the lookup address, 0 when no hit
- count  out  log2(DEPTH)+1  number of queued entries
- empty  out  1  count==0 and RegWrite==0

## Operation
- Circular FIFO with wr_ptr, rd_ptr (log2(DEPTH) bits, natural wrap) and count.
- Accept: wb_valid && wb_ready at a clock edge. wb_ready = (count != DEPTH). It is independent of drain in the same cycle, so there is no full-and-pop bypass.
- wb_reg==0 requests are accepted (handshake completes) but discarded: nothing is enqueued and count is unchanged.
- Drain: at an edge where count>0 and rd_stall==0, pop the head. RegWrite, WriteRegister and WriteData_reg are registered from the head entry and RegWrite is high for the following cycle only. At an edge with no pop, RegWrite goes to 0, and WriteRegister and WriteData_reg hold their last values.
- Simultaneous accept and pop: count unchanged, both pointers advance.
- Order: writes reach the register file strictly in acceptance order, including repeated writes to the same register.
- Forwarding is combinational over the valid queue entries plus the output stage (when RegWrite==1). Priority is the newest queued entry, then older queued entries, then the output stage. Address 0 never hits. Lookups do not see same-cycle wb_* inputs.
- count and empty are derived from registered state only.

## Timing
- Reset (async assert, sync release) state:
  - ptrs=0, count=0
  - RegWrite=0, WriteRegister=0, WriteData_reg=0
  - wb_ready=1, empty=1
  - fwd_hit*=0, fwd_data*=0
- Reset mid-operation drops all pending writes. RegWrite deasserts immediately on reset assertion.
- Latency with no stall: accepted at edge k, popped at edge k+1, RegWrite high during cycle k+1..k+2.
- Forwarding is valid from the cycle after acceptance until the cycle the write is on the port, inclusive.
- Throughput: one write per cycle sustained while rd_stall==0.
- rd_stall held high: the queue fills to DEPTH, then wb_ready=0. The first pop occurs at the first edge with rd_stall==0.

## Test plan
- Reset: assert rst_n=0 mid-queue with count=3 -> RegWrite=0 and count=0 immediately; after release, wb_ready=1 and empty=1.
- Single write: wb_reg=5, wb_data=0xDEADBEEF with rd_stall=0 -> RegWrite=1 exactly one cycle, two edges later, with WriteRegister=5 and WriteData_reg=0xDEADBEEF; fwd_reg1=5 hits with 0xDEADBEEF in the intervening cycle.
- Fill under stall: rd_stall=1, offer 5 writes to r1..r5 -> first 4 accepted, wb_ready=0 on the fifth, count=4; release stall -> r1..r4 written in order on 4 consecutive cycles, then r5 accepted and written.
- Same-register forwarding: enqueue r7=0x11, r7=0x22 under stall -> fwd_data1=0x22; drain -> port shows 0x11 then 0x22, and forwarding tracks the newest pending value each cycle.
- Register zero: wb_reg=0, wb_data=0xFFFF -> wb_ready handshake completes, count stays 0, RegWrite never asserts, fwd_reg2=0 never hits.
- Wrap-around: 10 back-to-back writes with rd_stall toggling every cycle -> all 10 appear on the port in order, count never exceeds 4, and no write is lost or duplicated.
